// File: rtl/booth_mult_iter_if.sv
// Issue/result bundle between the multdiv issue logic and the Booth multiplier.
interface booth_mult_iter_if;
   logic        ctrl_MULT;
   logic [31:0] data_operandA;
   logic [31:0] data_operandB;
   logic [31:0] data_result;
   logic [31:0] data_result_hi;
   logic        data_exception;
   logic        data_resultRDY;
   logic        busy;

   // Issue side: starts operations and consumes results.
   modport master (
      output ctrl_MULT, data_operandA, data_operandB,
      input  data_result, data_result_hi, data_exception, data_resultRDY, busy
   );

   // Multiplier side.
   modport slave (
      input  ctrl_MULT, data_operandA, data_operandB,
      output data_result, data_result_hi, data_exception, data_resultRDY, busy
   );
endinterface

// File: rtl/booth_mult_iter.sv
// Iterative radix-4 Booth signed multiplier, 32x32 -> 64 bits in 16 iterations.
// Each iteration adds 0/+-M/+-2M to the high word, then arithmetically shifts
// the 66-bit {A, Q} pair right by two.
module booth_mult_iter (
   input  logic              clock,
   input  logic              reset,
   booth_mult_iter_if.slave  bus
);
   localparam int unsigned WIDTH = 32;
   localparam int unsigned ITERS = WIDTH / 2;
   localparam int unsigned AW    = WIDTH + 2;
   localparam int unsigned SW    = AW + WIDTH;
   localparam int unsigned CW    = 4;

   typedef enum logic {IDLE, RUN} state_t;

   state_t          state;
   logic [AW-1:0]   m_reg;
   logic [AW-1:0]   a_reg;
   logic [WIDTH-1:0] q_reg;
   logic            q_1;
   logic [CW-1:0]   count;

   logic [AW-1:0]   m2_c;
   logic [AW-1:0]   sel_c;
   logic [AW-1:0]   sum_c;
   logic [SW-1:0]   shift_c;
   logic [AW:0]     sign_bits_c;
   logic            exc_c;

   // Booth recoding, partial-product add and the 66-bit arithmetic shift by 2.
   always_comb begin
      m2_c  = AW'(m_reg << 1);
      sel_c = '0;
      case ({q_reg[1:0], q_1})
         3'b001, 3'b010: sel_c = m_reg;
         3'b011:         sel_c = m2_c;
         3'b100:         sel_c = AW'(-m2_c);
         3'b101, 3'b110: sel_c = AW'(-m_reg);
         default:        sel_c = '0;
      endcase
      sum_c       = AW'(a_reg + sel_c);
      shift_c     = SW'($signed({sum_c, q_reg}) >>> 2);
      // Product fits in 32 signed bits only if every bit above bit 30 matches.
      sign_bits_c = {shift_c[SW-1:WIDTH], shift_c[WIDTH-1]};
      exc_c       = ~((&sign_bits_c) | ~(|sign_bits_c));
   end

   // Control FSM, datapath registers and registered result outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state              <= IDLE;
         m_reg              <= '0;
         a_reg              <= '0;
         q_reg              <= '0;
         q_1                <= 1'b0;
         count              <= '0;
         bus.data_result    <= '0;
         bus.data_result_hi <= '0;
         bus.data_exception <= 1'b0;
         bus.data_resultRDY <= 1'b0;
         bus.busy           <= 1'b0;
      end else begin
         bus.data_resultRDY <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.ctrl_MULT) begin
                  m_reg    <= {{2{bus.data_operandA[WIDTH-1]}}, bus.data_operandA};
                  a_reg    <= '0;
                  q_reg    <= bus.data_operandB;
                  q_1      <= 1'b0;
                  count    <= '0;
                  bus.busy <= 1'b1;
                  state    <= RUN;
               end
            end
            RUN: begin
               a_reg <= shift_c[SW-1:WIDTH];
               q_reg <= shift_c[WIDTH-1:0];
               q_1   <= q_reg[1];
               count <= CW'(count + CW'(1));
               if (count == CW'(ITERS - 1)) begin
                  bus.data_result    <= shift_c[WIDTH-1:0];
                  bus.data_result_hi <= shift_c[2*WIDTH-1:WIDTH];
                  bus.data_exception <= exc_c;
                  bus.data_resultRDY <= 1'b1;
                  bus.busy           <= 1'b0;
                  state              <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_booth_mult_iter.sv
// Self-checking bench for booth_mult_iter against a plain-arithmetic product model.
module tb_booth_mult_iter;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   booth_mult_iter_if bus ();

   booth_mult_iter dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   // Reference: full signed product and 32-bit overflow flag.
   function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] lo, output logic [31:0] hi,
                                 output logic exc);
      int     sa, sb, plo;
      longint p;
      sa  = a;
      sb  = b;
      p   = longint'(sa) * longint'(sb);
      lo  = p[31:0];
      hi  = p[63:32];
      plo = p[31:0];
      exc = (p != longint'(plo));
   endfunction

   // Pulse ctrl_MULT for one edge, scramble operands, wait for RDY.
   task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] lo, output logic [31:0] hi,
                        output logic exc, output int lat, output int bcnt);
      @(negedge clock);
      bus.ctrl_MULT     = 1'b1;
      bus.data_operandA = a;
      bus.data_operandB = b;
      @(negedge clock);
      bus.ctrl_MULT     = 1'b0;
      bus.data_operandA = $urandom;
      bus.data_operandB = $urandom;
      lat  = 0;
      bcnt = bus.busy ? 1 : 0;
      while (!bus.data_resultRDY && lat < 40) begin
         @(negedge clock);
         lat++;
         if (!bus.data_resultRDY && bus.busy) bcnt++;
      end
      lo  = bus.data_result;
      hi  = bus.data_result_hi;
      exc = bus.data_exception;
   endtask

   task automatic test_reset();
      #2 reset = 1'b0;
      #1;
      n_tests++;
      if ({bus.data_result, bus.data_result_hi, bus.data_exception,
           bus.data_resultRDY, bus.busy} !== 67'd0) begin
         n_fail++;
         $display("FAIL reset_outputs got lo=%h hi=%h exc=%b rdy=%b busy=%b want all 0",
                  bus.data_result, bus.data_result_hi, bus.data_exception,
                  bus.data_resultRDY, bus.busy);
      end
      repeat (2) @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic test_directed();
      logic [31:0] av [6] = '{32'd3, 32'hFFFF_FFF9, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'd0};
      logic [31:0] bv [6] = '{32'd4, 32'd6, 32'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1234_5678};
      logic [31:0] el [6] = '{32'h0000_000C, 32'hFFFF_FFD6, 32'hFFFF_FFFE, 32'h0, 32'h8000_0000, 32'h0};
      logic [31:0] eh [6] = '{32'h0, 32'hFFFF_FFFF, 32'h0, 32'h4000_0000, 32'h0, 32'h0};
      logic        ee [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [31:0] lo, hi;
      logic        exc;
      int          lat, bcnt;
      for (int i = 0; i < 6; i++) begin
         do_op(av[i], bv[i], lo, hi, exc, lat, bcnt);
         n_tests++;
         if ({lo, hi, exc} !== {el[i], eh[i], ee[i]}) begin
            n_fail++;
            $display("FAIL directed_%0d got lo=%h hi=%h exc=%b want lo=%h hi=%h exc=%b",
                     i, lo, hi, exc, el[i], eh[i], ee[i]);
         end
         n_tests++;
         if (lat !== 16 || bcnt !== 16) begin
            n_fail++;
            $display("FAIL latency_%0d got lat=%0d busy_cycles=%0d want 16/16", i, lat, bcnt);
         end
         @(negedge clock);
         n_tests++;
         if (bus.data_resultRDY !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rdy_pulse_%0d got rdy=%b busy=%b want 0/0", i,
                     bus.data_resultRDY, bus.busy);
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] ext [5] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
      logic [31:0] a, b, lo, hi, ml, mh;
      logic        exc, me;
      int          lat, bcnt;
      for (int i = 0; i < 30; i++) begin
         a = ($urandom_range(0, 3) == 0) ? ext[$urandom_range(0, 4)] : $urandom;
         b = ($urandom_range(0, 3) == 0) ? ext[$urandom_range(0, 4)] : $urandom;
         if ($urandom_range(0, 2) == 0) b = 32'($signed(16'($urandom)));
         model(a, b, ml, mh, me);
         do_op(a, b, lo, hi, exc, lat, bcnt);
         n_tests++;
         if ({lo, hi, exc} !== {ml, mh, me} || lat !== 16) begin
            n_fail++;
            $display("FAIL random_%0d a=%h b=%h got lo=%h hi=%h exc=%b lat=%0d want lo=%h hi=%h exc=%b lat=16",
                     i, a, b, lo, hi, exc, lat, ml, mh, me);
         end
      end
   endtask

   task automatic test_start_while_busy();
      logic [31:0] ml, mh;
      logic        me;
      int          lat, extra;
      model(32'hFFFF_1234, 32'h0001_0203, ml, mh, me);
      @(negedge clock);
      bus.ctrl_MULT = 1'b1;
      bus.data_operandA = 32'hFFFF_1234;
      bus.data_operandB = 32'h0001_0203;
      @(negedge clock);
      bus.ctrl_MULT = 1'b0;
      repeat (5) @(negedge clock);
      bus.ctrl_MULT = 1'b1;
      bus.data_operandA = 32'd9;
      bus.data_operandB = 32'd9;
      @(negedge clock);
      bus.ctrl_MULT = 1'b0;
      lat = 6;
      while (!bus.data_resultRDY && lat < 40) begin
         @(negedge clock);
         lat++;
      end
      n_tests++;
      if ({bus.data_result, bus.data_result_hi, bus.data_exception} !== {ml, mh, me} || lat !== 16) begin
         n_fail++;
         $display("FAIL busy_ignore got lo=%h hi=%h exc=%b lat=%0d want lo=%h hi=%h exc=%b lat=16",
                  bus.data_result, bus.data_result_hi, bus.data_exception, lat, ml, mh, me);
      end
      extra = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (bus.data_resultRDY || bus.busy) extra++;
      end
      n_tests++;
      if (extra !== 0) begin
         n_fail++;
         $display("FAIL busy_ignore_no_run got active_cycles=%0d want 0", extra);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] lo, hi, ml, mh;
      logic        exc, me;
      int          lat, bcnt;
      model(32'hDEAD_BEEF, 32'h0000_0007, ml, mh, me);
      do_op(32'hDEAD_BEEF, 32'h0000_0007, lo, hi, exc, lat, bcnt);
      n_tests++;
      if ({lo, hi, exc} !== {ml, mh, me}) begin
         n_fail++;
         $display("FAIL b2b_first got lo=%h hi=%h exc=%b want lo=%h hi=%h exc=%b",
                  lo, hi, exc, ml, mh, me);
      end
      bus.ctrl_MULT = 1'b1;
      bus.data_operandA = 32'd5;
      bus.data_operandB = 32'd5;
      @(negedge clock);
      bus.ctrl_MULT = 1'b0;
      bus.data_operandA = $urandom;
      repeat (3) @(negedge clock);
      n_tests++;
      if ({bus.data_result, bus.data_result_hi, bus.data_exception, bus.busy} !== {ml, mh, me, 1'b1}) begin
         n_fail++;
         $display("FAIL result_hold got lo=%h hi=%h exc=%b busy=%b want lo=%h hi=%h exc=%b busy=1",
                  bus.data_result, bus.data_result_hi, bus.data_exception, bus.busy, ml, mh, me);
      end
      lat = 3;
      while (!bus.data_resultRDY && lat < 40) begin
         @(negedge clock);
         lat++;
      end
      n_tests++;
      if ({bus.data_result, bus.data_result_hi, bus.data_exception} !== {32'd25, 32'd0, 1'b0} || lat !== 16) begin
         n_fail++;
         $display("FAIL b2b_second got lo=%h hi=%h exc=%b lat=%0d want lo=00000019 hi=0 exc=0 lat=16",
                  bus.data_result, bus.data_result_hi, bus.data_exception, lat);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] lo, hi;
      logic        exc;
      int          lat, bcnt, rdy_seen;
      @(negedge clock);
      bus.ctrl_MULT = 1'b1;
      bus.data_operandA = 32'h7FFF_0001;
      bus.data_operandB = 32'h0003_0000;
      @(negedge clock);
      bus.ctrl_MULT = 1'b0;
      repeat (8) @(negedge clock);
      #2 reset = 1'b0;
      #1;
      n_tests++;
      if ({bus.data_result, bus.data_result_hi, bus.data_exception,
           bus.data_resultRDY, bus.busy} !== 67'd0) begin
         n_fail++;
         $display("FAIL reset_mid_async got lo=%h hi=%h exc=%b rdy=%b busy=%b want all 0",
                  bus.data_result, bus.data_result_hi, bus.data_exception,
                  bus.data_resultRDY, bus.busy);
      end
      repeat (2) @(negedge clock);
      reset = 1'b1;
      rdy_seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (bus.data_resultRDY || bus.busy) rdy_seen++;
      end
      n_tests++;
      if (rdy_seen !== 0) begin
         n_fail++;
         $display("FAIL reset_mid_abort got active_cycles=%0d want 0", rdy_seen);
      end
      do_op(32'd2, 32'd3, lo, hi, exc, lat, bcnt);
      n_tests++;
      if ({lo, hi, exc} !== {32'd6, 32'd0, 1'b0} || lat !== 16) begin
         n_fail++;
         $display("FAIL reset_mid_rerun got lo=%h hi=%h exc=%b lat=%0d want lo=6 hi=0 exc=0 lat=16",
                  lo, hi, exc, lat);
      end
   endtask

   initial begin
      bus.ctrl_MULT     = 1'b0;
      bus.data_operandA = '0;
      bus.data_operandB = '0;
      test_reset();
      test_directed();
      test_random();
      test_start_while_busy();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/booth_mult_iter.md
Name: booth_mult_iter

Overview:
- Iterative radix-4 Booth signed multiplier: 32x32 -> 64-bit product, 16 iteration cycles per operation.
- Control FSM plus partial-product datapath that drives the 66-bit arithmetic right shifter used in the multdiv unit.
- Each iteration adds 0/±M/±2M to the running high word, then shifts the 66-bit {high, multiplier} pair right by 2.
- Sits between the processor's multdiv issue logic (ctrl_MULT, operands) and the multdiv result mux (result, exception, ready).

Parameters:
- WIDTH, 32, operand width; the 66-bit shifter interface fixes this at 32.
- ITERS, 16, radix-4 iterations, equal to WIDTH/2.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- ctrl_MULT  in  1  start pulse; operands are sampled on the same edge
- data_operandA  in  32  multiplicand M, signed
- data_operandB  in  32  multiplier Q, signed
- data_result  out  32  low 32 bits of the product
- data_result_hi  out  32  high 32 bits of the product
- data_exception  out  1  product does not fit in signed 32 bits
- data_resultRDY  out  1  one-cycle pulse: result valid
- busy  out  1  operation in progress

Behaviour:
- Reset: reset low clears state to IDLE immediately, without waiting for a clock edge. All outputs read 0 while reset is low, and all internal registers clear.
- States: IDLE and RUN. Iteration counter is 4 bits.
- IDLE, ctrl_MULT=1 at an edge:
  - Latch M into a 34-bit sign-extended register; Q -> Q[31:0]; A <= 0 (34 bits); q_1 <= 0; count <= 0.
  - Go to RUN; busy=1 from the next cycle.
- RUN, each edge:
  - Booth select from {Q[1],Q[0],q_1}: 000/111 -> 0; 001/010 -> +M; 011 -> +2M; 100 -> -2M; 101/110 -> -M.
  - sum = A + sel, computed at 34 bits, no overflow by construction.
  - The 66-bit shifter gets {sum[33:0], Q[31:0]} with shiftamount=2.
  - Shifter out[65:32] -> A; out[31:0] -> Q; q_1 <= old Q[1]; count increments.
- Finish: on the edge where count==15, the last iteration completes.
  - Register the outputs: data_result=Q, data_result_hi=A[31:0].
  - data_exception=1 unless A[33:0] and Q[31] are all equal.
  - data_resultRDY=1 for the following cycle only; return to IDLE with busy=0.
- Latency: data_resultRDY is high in the cycle after the 16th edge following the edge that sampled ctrl_MULT.
- Result hold: data_result, data_result_hi and data_exception hold until the next completion or reset. They are not cleared at start.
- ctrl_MULT while in RUN: ignored; the operation in flight is unaffected.
- ctrl_MULT in the cycle where data_resultRDY=1: accepted, because the state is already IDLE. This gives back-to-back operations.
- Reset during RUN: abort; no data_resultRDY pulse; outputs return to 0.
- Operand changes after the start edge: no effect on the operation.

Test Plan:
- A=3, B=4, one ctrl_MULT pulse -> RDY exactly 16 edges later; result=0x0000000C, hi=0, exception=0; busy high for 16 cycles.
- A=-7, B=6 -> result=0xFFFFFFD6, hi=0xFFFFFFFF, exception=0.
- A=0x7FFFFFFF, B=2 -> result=0xFFFFFFFE, hi=0x00000000, exception=1.
- A=0x80000000, B=0x80000000 (exercises the 2M extreme) -> hi=0x40000000, result=0, exception=1. A=0x80000000, B=-1 -> result=0x80000000, hi=0, exception=1.
- Start while busy and back-to-back:
  - Pulse ctrl_MULT with new operands at cycle 5 of a run -> ignored; the first result is unchanged.
  - Pulse ctrl_MULT in the RDY cycle with A=5, B=5 -> second RDY 16 edges later with result 25.
- Reset mid-op: drop reset at iteration 8 -> all outputs 0 asynchronously, busy=0, no RDY. After release, a fresh 2x3 run -> result 6.
